// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - 3-stage pipelined radix-2 DIT complex butterfly, Y = A + W*B, Z = A - W*B.
// Optional BUTTERFLY_SAT_EN: saturate overflowing outputs instead of wrapping.
module butterfly_pipe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_conj,
  input  logic             in_scale,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic [WIDTH-1:0] w_re,
  input  logic [WIDTH-1:0] w_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic [WIDTH-1:0] z_re,
  output logic [WIDTH-1:0] z_im,
  output logic             ovf_flag,
  input  logic             ovf_clear
);

  localparam int PW = 2*WIDTH + 2;
  localparam int SW = PW + 1;
  localparam logic signed [PW-1:0] RND  = PW'(2**(FRAC-1));
  localparam logic signed [SW-1:0] MAXV = SW'(2**(WIDTH-1) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2**(WIDTH-1));
`ifdef BUTTERFLY_SAT_EN
  localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [PW-1:0] sx_p(input logic [WIDTH-1:0] v);
    return {{(PW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sx_s(input logic [WIDTH-1:0] v);
    return {{(SW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Returns {overflow, output component} after optional halving and wrap/saturate.
  function automatic logic [WIDTH:0] finish_comp(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] r;
    logic                 ovf;
    logic [WIDTH-1:0]     o;
    r   = sc ? (s >>> 1) : s;
    ovf = (r > MAXV) || (r < MINV);
    o   = r[WIDTH-1:0];
`ifdef BUTTERFLY_SAT_EN
    if (ovf) o = r[SW-1] ? MIN_W : MAX_W;
`endif
    return {ovf, o};
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic             s1_valid, s1_conj, s1_scale;
  logic [WIDTH-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_conj  <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_conj  <= in_conj;
      s1_scale <= in_scale;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_b_re  <= b_re;
      s1_b_im  <= b_im;
      s1_w_re  <= w_re;
      s1_w_im  <= w_im;
    end
  end

  // Negated twiddle needs WIDTH+1 bits so that -(-2^(WIDTH-1)) stays exact.
  logic signed [WIDTH:0]  wim_x, wi_eff;
  logic signed [PW-1:0]   bre_x, bim_x, wre_x, wi_x, p_re, p_im, t_re, t_im;

  always_comb begin
    wim_x  = {s1_w_im[WIDTH-1], s1_w_im};
    wi_eff = s1_conj ? -wim_x : wim_x;
    bre_x  = sx_p(s1_b_re);
    bim_x  = sx_p(s1_b_im);
    wre_x  = sx_p(s1_w_re);
    wi_x   = {{(PW-WIDTH-1){wi_eff[WIDTH]}}, wi_eff};
    p_re   = bre_x * wre_x - bim_x * wi_x;
    p_im   = bre_x * wi_x + bim_x * wre_x;
    t_re   = (p_re + RND) >>> FRAC;
    t_im   = (p_im + RND) >>> FRAC;
  end

  logic             s2_valid, s2_scale;
  logic [WIDTH-1:0] s2_a_re, s2_a_im;
  logic [PW-1:0]    s2_t_re, s2_t_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_t_re  <= '0;
      s2_t_im  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      s2_t_re  <= t_re;
      s2_t_im  <= t_im;
    end
  end

  logic signed [SW-1:0] ax_re, ax_im, tx_re, tx_im;
  logic [WIDTH:0]       fy_re, fy_im, fz_re, fz_im;
  logic                 any_ovf;

  always_comb begin
    ax_re   = sx_s(s2_a_re);
    ax_im   = sx_s(s2_a_im);
    tx_re   = {s2_t_re[PW-1], s2_t_re};
    tx_im   = {s2_t_im[PW-1], s2_t_im};
    fy_re   = finish_comp(ax_re + tx_re, s2_scale);
    fy_im   = finish_comp(ax_im + tx_im, s2_scale);
    fz_re   = finish_comp(ax_re - tx_re, s2_scale);
    fz_im   = finish_comp(ax_im - tx_im, s2_scale);
    any_ovf = fy_re[WIDTH] | fy_im[WIDTH] | fz_re[WIDTH] | fz_im[WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      z_re      <= '0;
      z_im      <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      y_re      <= fy_re[WIDTH-1:0];
      y_im      <= fy_im[WIDTH-1:0];
      z_re      <= fz_re[WIDTH-1:0];
      z_im      <= fz_im[WIDTH-1:0];
    end
  end

  // A set in the same cycle as a clear wins, so no overflow event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if (en && s2_valid && any_ovf) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clear) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - scoreboard bench for butterfly_pipe (WIDTH=8, FRAC=7).
module tb_butterfly_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_ready, in_conj = 1'b0, in_scale = 1'b0;
  logic [7:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] y_re, y_im, z_re, z_im;
  logic       ovf_flag, ovf_clear = 1'b0;

  always #5 clk = ~clk;

  butterfly_pipe #(.WIDTH(8), .FRAC(7)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_re(y_re), .y_im(y_im), .z_re(z_re), .z_im(z_im),
    .ovf_flag(ovf_flag), .ovf_clear(ovf_clear)
  );

  typedef struct packed {logic [7:0] yr, yi, zr, zi;} res_t;

  res_t exp_q[$];
  int   n_tests = 0, n_fail = 0, n_push = 0, n_pop = 0;

`ifdef BUTTERFLY_SAT_EN
  localparam res_t OVF_RES = {8'h7F, 8'h00, 8'h01, 8'h00};
`else
  localparam res_t OVF_RES = {8'hFD, 8'h00, 8'h01, 8'h00};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] ar, ai, br, bi, wr, wi, input logic cj, sc);
    int ar_i, ai_i, br_i, bi_i, wr_i, wi_i, p_r, p_i, t_r, t_i;
    int s[4];
    logic [7:0] o[4];
    ar_i = int'($signed(ar)); ai_i = int'($signed(ai));
    br_i = int'($signed(br)); bi_i = int'($signed(bi));
    wr_i = int'($signed(wr)); wi_i = int'($signed(wi));
    if (cj) wi_i = -wi_i;
    p_r = br_i * wr_i - bi_i * wi_i;
    p_i = br_i * wi_i + bi_i * wr_i;
    t_r = (p_r + 64) >>> 7;
    t_i = (p_i + 64) >>> 7;
    s[0] = ar_i + t_r; s[1] = ai_i + t_i; s[2] = ar_i - t_r; s[3] = ai_i - t_i;
    for (int i = 0; i < 4; i++) begin
      if (sc) s[i] = s[i] >>> 1;
      o[i] = 8'(s[i]);
`ifdef BUTTERFLY_SAT_EN
      if (s[i] > 127) o[i] = 8'h7F;
      else if (s[i] < -128) o[i] = 8'h80;
`endif
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [7:0] ar, ai, br, bi, wr, wi, input logic cj, sc, input res_t e);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    in_conj = cj; in_scale = sc; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        n_push++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_tests++; n_fail++;
    $display("FAIL send_timeout: in_ready never high, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_after_send(input string name);
    int lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, lat, 3);
  endtask

  logic stalled_prev = 1'b0;
  res_t held;

  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_hold_data", {y_re, y_im, z_re, z_im}, held);
        check("stall_hold_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_output: got %02h%02h%02h%02h, expected none", y_re, y_im, z_re, z_im);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("result", {y_re, y_im, z_re, z_im}, e);
        end
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      stalled_prev = out_valid && !out_ready;
      held = {y_re, y_im, z_re, z_im};
    end
  end

  initial begin
    logic [7:0] v[6];
    logic       cj, sc;
    #1;
    check("reset_state", {out_valid, ovf_flag, y_re, y_im, z_re, z_im}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    send(8'h10, 8'h08, 8'h20, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, {8'h20, 8'h08, 8'h00, 8'h08});
    latency_after_send("basic_latency");
    drain();
    check("basic_no_ovf", ovf_flag, 0);

    send(8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 1'b1, 1'b0, {8'h00, 8'hF0, 8'h00, 8'h10});
    send(8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 1'b0, 1'b0, {8'h00, 8'h10, 8'h00, 8'hF0});
    send(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b1, {8'h7E, 8'h00, 8'h00, 8'h00});
    drain();
    check("scaled_no_ovf", ovf_flag, 0);

    send(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, OVF_RES);
    drain();
    check("ovf_set", ovf_flag, 1);

    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    check("ovf_clear_alone", ovf_flag, 0);
    send(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, OVF_RES);
    send(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, OVF_RES);
    check("sticky_pre", ovf_flag, 0);
    @(posedge clk); #1;
    check("sticky_first_set", ovf_flag, 1);
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    check("sticky_set_beats_clear", ovf_flag, 1);
    @(posedge clk); #1;
    check("sticky_clear_next", ovf_flag, 0);
    ovf_clear = 1'b0;
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < 6; j++) v[j] = 8'($urandom);
          cj = 1'($urandom);
          sc = 1'($urandom);
          send(v[0], v[1], v[2], v[3], v[4], v[5], cj, sc, model(v[0], v[1], v[2], v[3], v[4], v[5], cj, sc));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pop, n_push);

    send(8'h10, 8'h08, 8'h20, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, {8'h20, 8'h08, 8'h00, 8'h08});
    send(8'h01, 8'h02, 8'h20, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, {8'h11, 8'h02, 8'hF1, 8'h02});
    send(8'h03, 8'h04, 8'h20, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, {8'h13, 8'h04, 8'hF3, 8'h04});
    check("pre_reset_valid", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {out_valid, y_re, y_im, z_re, z_im}, 0);
    exp_q.delete();
    n_pop = 0; n_push = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", in_ready, 1);
    send(8'h10, 8'h08, 8'h20, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, {8'h20, 8'h08, 8'h00, 8'h08});
    latency_after_send("post_reset_latency");
    drain();
    check("post_reset_count", n_pop, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
